// File: rtl/gaussian_pkg.sv
// Shared types and arithmetic for the 3x3 Gaussian blur stage.
// - PIX_W           : pixel width (signed two's complement, integer)
// - KERNEL_SHIFT    : normalisation shift (kernel sum = 16)
// - ACC_EXTRA       : accumulator growth bits beyond PIX_W
// - gauss3x3()      : weighted 3x3 sum, floor-divided by 16, truncated to PIX_W
package gaussian_pkg;

  localparam int unsigned PIX_W        = 16;
  localparam int unsigned KERNEL_SHIFT = 4;
  localparam int unsigned ACC_EXTRA    = 4;
  localparam int unsigned ACC_W        = PIX_W + ACC_EXTRA;

  typedef logic [PIX_W-1:0]             pixel_t;
  // Indexed [row][col]; row 0 is the oldest line, col 2 the newest column.
  typedef logic [2:0][2:0][PIX_W-1:0]   window_t;
  typedef logic signed [ACC_W-1:0]      acc_t;

  // Kernel [1 2 1; 2 4 2; 1 2 1] stored as log2 of each weight so taps are pure shifts.
  localparam int unsigned KERNEL_WEIGHT_LOG2 [3][3] = '{'{0, 1, 0}, '{1, 2, 1}, '{0, 1, 0}};

  function automatic pixel_t gauss3x3(input window_t win);
    acc_t acc;
    acc_t tap;
    acc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap = {{ACC_EXTRA{win[r][c][PIX_W-1]}}, win[r][c]};
        acc = acc + (tap <<< KERNEL_WEIGHT_LOG2[r][c]);
      end
    end
    // Arithmetic shift then truncation == taking the bit field above the fraction.
    return acc[KERNEL_SHIFT +: PIX_W];
  endfunction

endpackage

// File: rtl/gaussian_filter_3x3_if.sv
// Pixel stream bundle for the Gaussian stage: input stream (pixel_in/in_valid/in_ready) and
// output stream (pixel_out/out_valid/out_ready/out_last).
// - master : the environment side (drives pixel_in, in_valid, out_ready)
// - slave  : the filter side (drives in_ready, pixel_out, out_valid, out_last)
interface gaussian_filter_3x3_if #(
  parameter int unsigned PIXEL_BIT_WIDTH = 16
);
  logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
  logic                       in_valid;
  logic                       in_ready;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  modport master (
    output pixel_in, in_valid, out_ready,
    input  in_ready, pixel_out, out_valid, out_last
  );

  modport slave (
    input  pixel_in, in_valid, out_ready,
    output in_ready, pixel_out, out_valid, out_last
  );
endinterface

// File: rtl/gaussian_filter_3x3_line_buffer.sv
// One line of pixel storage, 1 read / 1 write port sharing one address.
// - clk   : clock
// - we    : write enable
// - addr  : shared read/write index (driven from the registered column counter)
// - wdata : data written at addr on the clock edge
// - rdata : current content at addr (old value when reading and writing the same address)
module gaussian_filter_3x3_line_buffer #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 48,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// Streaming 3x3 Gaussian blur, "valid"-mode convolution of a ROWS x COLS raster.
// Emits (ROWS-2) x (COLS-2) pixels in raster order, 1 cycle after the completing input.
// - clk    : clock
// - reset  : synchronous, active-high
// - stream : slave side of the pixel stream bundle (input and output valid/ready streams)
module gaussian_filter_3x3
  import gaussian_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH = PIX_W,
  parameter int unsigned ROWS            = 48,
  parameter int unsigned COLS            = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  gaussian_filter_3x3_if.slave stream
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0]           col_q;
  logic [ROW_W-1:0]           row_q;
  window_t                    win_q, win_d;
  logic [PIXEL_BIT_WIDTH-1:0] lb0_rdata, lb1_rdata;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_out_q;
  logic                       out_valid_q, out_last_q;
  logic                       in_ready, in_accept, new_result, frame_end;

  // Single output register: free when empty or draining this cycle.
  assign in_ready   = ~out_valid_q | stream.out_ready;
  assign in_accept  = stream.in_valid & in_ready;
  // Row/col >= 2 also keeps stale line-buffer data and previous-frame lines out of any window.
  assign new_result = in_accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign frame_end  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign stream.in_ready  = in_ready;
  assign stream.pixel_out = pixel_out_q;
  assign stream.out_valid = out_valid_q;
  assign stream.out_last  = out_last_q;

  // lb0 holds row-2, lb1 holds row-1; on accept lb1 ages into lb0 and the new pixel enters lb1.
  gaussian_filter_3x3_line_buffer #(
    .Width(PIXEL_BIT_WIDTH),
    .Depth(COLS)
  ) u_lb0 (
    .clk  (clk),
    .we   (in_accept),
    .addr (col_q),
    .wdata(lb1_rdata),
    .rdata(lb0_rdata)
  );

  gaussian_filter_3x3_line_buffer #(
    .Width(PIXEL_BIT_WIDTH),
    .Depth(COLS)
  ) u_lb1 (
    .clk  (clk),
    .we   (in_accept),
    .addr (col_q),
    .wdata(stream.pixel_in),
    .rdata(lb1_rdata)
  );

  // Window shifted left with the new column appended; the result is computed from this so the
  // output lands one cycle after the completing accept.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb0_rdata;
    win_d[1][2] = lb1_rdata;
    win_d[2][2] = stream.pixel_in;
  end

  always_ff @(posedge clk) begin
    if (in_accept) begin
      win_q <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pixel_out_q <= '0;
    end else begin
      if (in_accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      if (new_result) begin
        out_valid_q <= 1'b1;
        out_last_q  <= frame_end;
        pixel_out_q <= gauss3x3(win_d);
      end else if (out_valid_q && stream.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_filter_3x3.sv
// Directed bench for gaussian_filter_3x3: constant, ramp, impulse, signed and checkerboard
// frames with random valid/ready, back-to-back frames, an output stall and a mid-frame reset.
module tb_gaussian_filter_3x3;

  localparam int ROWS    = 48;
  localparam int COLS    = 48;
  localparam int OUT_C   = COLS - 2;
  localparam int OUT_N   = (ROWS - 2) * (COLS - 2);
  localparam int FRAME_N = ROWS * COLS;
  localparam int BUDGET  = 30000;

  localparam int P_CONST = 0;
  localparam int P_RAMP  = 1;
  localparam int P_IMP   = 2;
  localparam int P_NEG3  = 3;
  localparam int P_CHECK = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  gaussian_filter_3x3_if #(.PIXEL_BIT_WIDTH(16)) bus ();

  gaussian_filter_3x3 #(
    .PIXEL_BIT_WIDTH(16),
    .ROWS           (ROWS),
    .COLS           (COLS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .stream(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int pat, input int r, input int c);
    case (pat)
      P_CONST: return 16'd100;
      P_RAMP:  return 16'(r * COLS + c);
      P_IMP:   return (r == 10 && c == 10) ? 16'd16 : 16'd0;
      P_NEG3:  return 16'hFFFD;
      default: return (((r + c) % 2) == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Hand-derived expectations for output k (centre at (i+1, j+1)).
  function automatic logic [15:0] expect_pix(input int pat, input int k);
    int i, j, di, dj;
    i  = k / OUT_C;
    j  = k % OUT_C;
    di = (i + 1 > 10) ? (i + 1 - 10) : (10 - i - 1);
    dj = (j + 1 > 10) ? (j + 1 - 10) : (10 - j - 1);
    case (pat)
      P_CONST: return 16'd100;
      P_RAMP:  return 16'((i + 1) * COLS + (j + 1));
      P_IMP:   return (di <= 1 && dj <= 1) ? 16'((2 - di) * (2 - dj)) : 16'd0;
      P_NEG3:  return 16'hFFFD;
      default: return 16'hFFFF; // -8/16 floors to -1 whichever the centre parity
    endcase
  endfunction

  task automatic drive(input int pat, input int n_pix, input bit rnd);
    int n;
    int budget;
    int p;
    n = 0;
    budget = 0;
    while (n < n_pix && budget < BUDGET) begin
      p = n % FRAME_N;
      bus.in_valid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      bus.pixel_in = pix(pat, p / COLS, p % COLS);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) n++;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (n < n_pix) check_val("drive_timeout", n, n_pix);
  endtask

  task automatic monitor(input int pat, input int n_out, input bit rnd, input int stall_at);
    int got;
    int budget;
    int stall_left;
    int k;
    bit stall_done;
    bit held_ok;
    logic [15:0] held;
    got = 0;
    budget = 0;
    stall_left = 0;
    stall_done = 1'b0;
    held_ok = 1'b0;
    held = '0;
    while (got < n_out && budget < BUDGET) begin
      if (stall_at >= 0 && got == stall_at && !stall_done) begin
        stall_left = 20;
        stall_done = 1'b1;
      end
      if (stall_left > 0) bus.out_ready = 1'b0;
      else bus.out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      @(negedge clk);
      if (stall_left > 0) begin
        if (bus.out_valid) begin
          check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
          if (held_ok) check_val("stall_hold", 32'(bus.pixel_out), 32'(held));
          held = bus.pixel_out;
          held_ok = 1'b1;
        end
        stall_left--;
      end else if (bus.out_valid && bus.out_ready) begin
        k = got % OUT_N;
        check_val($sformatf("pix_p%0d_k%0d", pat, k), 32'(bus.pixel_out), 32'(expect_pix(pat, k)));
        check_val($sformatf("last_p%0d_k%0d", pat, k), 32'(bus.out_last), 32'(k == OUT_N - 1));
        got++;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    bus.out_ready = 1'b0;
    check_val($sformatf("out_count_p%0d", pat), got, n_out);
  endtask

  task automatic run(input int pat, input int frames, input bit rnd, input int stall_at);
    fork
      drive(pat, frames * FRAME_N, rnd);
      monitor(pat, frames * OUT_N, rnd, stall_at);
    join
    @(posedge clk);
    #1;
    check_val("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check_val({tag, "_pixel_out"}, 32'(bus.pixel_out), 32'd0);
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.pixel_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    do_reset("reset0");

    run(P_CONST, 1, 1'b1, -1);
    run(P_RAMP, 2, 1'b0, -1);   // back-to-back, no idle cycles
    run(P_IMP, 1, 1'b1, -1);
    run(P_NEG3, 1, 1'b1, -1);
    run(P_CHECK, 1, 1'b1, -1);
    run(P_RAMP, 1, 1'b0, 1000); // 20-cycle output stall mid-frame

    // Abandon a frame after 500 accepts, with an output likely pending.
    bus.out_ready = 1'b1;
    drive(P_RAMP, 500, 1'b0);
    do_reset("reset_mid");
    run(P_RAMP, 1, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
